// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle: stage state from the pipeline, register controls back to it.
// master = the hazard controller, slave = the pipeline datapath.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             memRead_EX;
    logic [4:0]       targetReg_EX;
    logic [4:0]       Rn_ID;
    logic [4:0]       Rm_ID;
    logic             useRn_ID;
    logic             useRm_ID;
    logic             PCSrc;
    logic             mem_req;
    logic             mem_ready;
    logic             pc_we;
    logic             if_id_we;
    logic             id_ex_we;
    logic             ex_mem_we;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             mem_wb_bubble;
    logic             mem_err;
    logic [1:0]       hz_state;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        input  memRead_EX, targetReg_EX, Rn_ID, Rm_ID, useRn_ID, useRm_ID,
               PCSrc, mem_req, mem_ready,
        output pc_we, if_id_we, id_ex_we, ex_mem_we, if_id_flush, id_ex_bubble,
               mem_wb_bubble, mem_err, hz_state, stall_cnt, flush_cnt
    );

    modport slave (
        output memRead_EX, targetReg_EX, Rn_ID, Rm_ID, useRn_ID, useRm_ID,
               PCSrc, mem_req, mem_ready,
        input  pc_we, if_id_we, id_ex_we, ex_mem_we, if_id_flush, id_ex_bubble,
               mem_wb_bubble, mem_err, hz_state, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: load-use, taken branch, data-memory wait.
// Optional HAZARD_PERF_EN adds saturating stall/flush performance counters.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input logic                   clk,
    input logic                   rst,
    pipeline_hazard_ctrl_if.master hz
);
    localparam int TW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_HOLD  = 2'd1,
        MEM_WAIT = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            err_q, err_d;
    logic            lu, ms;
    logic            pc_we, if_id_we, id_ex_we, ex_mem_we;
    logic            if_id_flush, id_ex_bubble, mem_wb_bubble;

    assign lu = hz.memRead_EX && (hz.targetReg_EX != 5'd31) &&
                ((hz.useRn_ID && (hz.Rn_ID == hz.targetReg_EX)) ||
                 (hz.useRm_ID && (hz.Rm_ID == hz.targetReg_EX)));
    assign ms = hz.mem_req && !hz.mem_ready;

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        err_d         = err_q;
        pc_we         = 1'b1;
        if_id_we      = 1'b1;
        id_ex_we      = 1'b1;
        ex_mem_we     = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_bubble  = 1'b0;
        mem_wb_bubble = 1'b0;
        case (state_q)
            RUN, LU_HOLD: begin
                if (ms) begin
                    {pc_we, if_id_we, id_ex_we, ex_mem_we} = '0;
                    mem_wb_bubble = 1'b1;
                    state_d       = MEM_WAIT;
                    timer_d       = TW'(1);
                end else if (state_q == RUN && hz.PCSrc) begin
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                    state_d      = RUN;
                end else if (state_q == RUN && lu) begin
                    pc_we        = 1'b0;
                    if_id_we     = 1'b0;
                    id_ex_bubble = 1'b1;
                    state_d      = LU_HOLD;
                end else begin
                    state_d = RUN;
                end
            end
            MEM_WAIT: begin
                // EX is frozen here, so branch and load-use wait until exit.
                if (hz.mem_ready) begin
                    state_d = RUN;
                    timer_d = '0;
                end else begin
                    {pc_we, if_id_we, id_ex_we, ex_mem_we} = '0;
                    mem_wb_bubble = 1'b1;
                    if (timer_q == TW'(MEM_TIMEOUT)) begin
                        err_d = 1'b1;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end
            default: state_d = RUN;
        endcase
        if (rst) begin
            {pc_we, if_id_we, id_ex_we, ex_mem_we} = '0;
            {if_id_flush, id_ex_bubble, mem_wb_bubble} = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            timer_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            err_q   <= err_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_q, flush_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_we && stall_q != '1) stall_q <= stall_q + 1'b1;
            if (if_id_flush && flush_q != '1) flush_q <= flush_q + 1'b1;
        end
    end

    assign hz.stall_cnt = stall_q;
    assign hz.flush_cnt = flush_q;
`else
    assign hz.stall_cnt = '0;
    assign hz.flush_cnt = '0;
`endif

    assign hz.pc_we         = pc_we;
    assign hz.if_id_we      = if_id_we;
    assign hz.id_ex_we      = id_ex_we;
    assign hz.ex_mem_we     = ex_mem_we;
    assign hz.if_id_flush   = if_id_flush;
    assign hz.id_ex_bubble  = id_ex_bubble;
    assign hz.mem_wb_bubble = mem_wb_bubble;
    assign hz.mem_err       = err_q;
    assign hz.hz_state      = state_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: vector table plus timeout/reset sequences.
// Counter expectations follow HAZARD_PERF_EN when it is defined.
module tb_pipeline_hazard_ctrl;
    localparam int CNT_W = 16;
    localparam int MT    = 15;

    // {pc_we, if_id_we, id_ex_we, ex_mem_we, if_id_flush, id_ex_bubble, mem_wb_bubble}
    localparam logic [6:0] O_RST  = 7'b0000_111;
    localparam logic [6:0] O_NORM = 7'b1111_000;
    localparam logic [6:0] O_MS   = 7'b0000_001;
    localparam logic [6:0] O_LU   = 7'b0011_010;
    localparam logic [6:0] O_FL   = 7'b1111_110;

    typedef struct {
        logic       rst;
        logic       mr;
        logic [4:0] tgt;
        logic [4:0] rn;
        logic [4:0] rm;
        logic       urn;
        logic       urm;
        logic       pcs;
        logic       req;
        logic       rdy;
        logic [6:0] o;
        logic       err;
        logic [1:0] st;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    logic [CNT_W-1:0] m_stall = '0;
    logic [CNT_W-1:0] m_flush = '0;
    vec_t tbl [19];

    pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic mr, input logic [4:0] tgt,
                                input logic [4:0] rn, input logic [4:0] rm,
                                input logic urn, input logic urm, input logic pcs,
                                input logic req, input logic rdy,
                                input logic [6:0] o, input logic err, input logic [1:0] st);
        vec_t v;
        v.rst = r; v.mr = mr; v.tgt = tgt; v.rn = rn; v.rm = rm;
        v.urn = urn; v.urm = urm; v.pcs = pcs; v.req = req; v.rdy = rdy;
        v.o = o; v.err = err; v.st = st;
        return v;
    endfunction

    task automatic run_vec(input string tag, input int idx, input vec_t v);
        logic [9:0]       act, exp;
        logic [2*CNT_W-1:0] cact, cexp;
        @(negedge clk);
        rst             = v.rst;
        hz.memRead_EX   = v.mr;
        hz.targetReg_EX = v.tgt;
        hz.Rn_ID        = v.rn;
        hz.Rm_ID        = v.rm;
        hz.useRn_ID     = v.urn;
        hz.useRm_ID     = v.urm;
        hz.PCSrc        = v.pcs;
        hz.mem_req      = v.req;
        hz.mem_ready    = v.rdy;
        #1;
        act = {hz.pc_we, hz.if_id_we, hz.id_ex_we, hz.ex_mem_we, hz.if_id_flush,
               hz.id_ex_bubble, hz.mem_wb_bubble, hz.mem_err, hz.hz_state};
        exp = {v.o, v.err, v.st};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] ctrl {we4,fl,idb,mwb,err,st}: got %b want %b", tag, idx, act, exp);
        end
        cact = {hz.stall_cnt, hz.flush_cnt};
        cexp = {m_stall, m_flush};
        total++;
        if (cact !== cexp) begin
            bad++;
            $display("FAIL %s[%0d] counters {stall,flush}: got %0d,%0d want %0d,%0d",
                     tag, idx, hz.stall_cnt, hz.flush_cnt, m_stall, m_flush);
        end
`ifdef HAZARD_PERF_EN
        if (v.rst) begin
            m_stall = '0;
            m_flush = '0;
        end else begin
            if (!v.o[6] && m_stall != '1) m_stall = m_stall + 1'b1;
            if (v.o[2] && m_flush != '1) m_flush = m_flush + 1'b1;
        end
`endif
    endtask

    initial begin
        hz.memRead_EX = 1'b0; hz.targetReg_EX = '0; hz.Rn_ID = '0; hz.Rm_ID = '0;
        hz.useRn_ID = 1'b0; hz.useRm_ID = 1'b0; hz.PCSrc = 1'b0;
        hz.mem_req = 1'b0; hz.mem_ready = 1'b0;

        //               rst mr tgt rn  rm  urn urm pcs req rdy  outputs  err st
        tbl[0]  = mk(1, 0, 0,  0,  0,  0, 0, 0, 0, 0, O_RST,  0, 0);
        tbl[1]  = mk(0, 0, 0,  0,  0,  0, 0, 0, 0, 0, O_NORM, 0, 0);
        tbl[2]  = mk(0, 1, 1,  1,  2,  1, 1, 0, 0, 0, O_LU,   0, 0);
        tbl[3]  = mk(0, 1, 1,  1,  2,  1, 1, 0, 0, 0, O_NORM, 0, 1);
        tbl[4]  = mk(0, 0, 0,  0,  0,  0, 0, 0, 0, 0, O_NORM, 0, 0);
        tbl[5]  = mk(0, 1, 31, 31, 31, 1, 1, 0, 0, 0, O_NORM, 0, 0);
        tbl[6]  = mk(0, 1, 5,  5,  5,  0, 1, 0, 0, 0, O_LU,   0, 0);
        tbl[7]  = mk(0, 0, 0,  0,  0,  0, 0, 0, 1, 0, O_MS,   0, 1);
        tbl[8]  = mk(0, 0, 0,  0,  0,  0, 0, 0, 1, 0, O_MS,   0, 2);
        tbl[9]  = mk(0, 0, 0,  0,  0,  0, 0, 0, 1, 1, O_NORM, 0, 2);
        tbl[10] = mk(0, 0, 1,  1,  0,  1, 0, 0, 0, 0, O_NORM, 0, 0);
        tbl[11] = mk(0, 1, 3,  3,  0,  1, 0, 1, 0, 0, O_FL,   0, 0);
        tbl[12] = mk(0, 0, 0,  0,  0,  0, 0, 0, 0, 0, O_NORM, 0, 0);
        tbl[13] = mk(0, 0, 0,  0,  0,  0, 0, 0, 1, 1, O_NORM, 0, 0);
        tbl[14] = mk(0, 0, 0,  0,  0,  0, 0, 1, 1, 0, O_MS,   0, 0);
        tbl[15] = mk(0, 1, 4,  4,  0,  1, 0, 1, 1, 0, O_MS,   0, 2);
        tbl[16] = mk(0, 0, 0,  0,  0,  0, 0, 1, 1, 0, O_MS,   0, 2);
        tbl[17] = mk(0, 0, 0,  0,  0,  0, 0, 0, 1, 1, O_NORM, 0, 2);
        tbl[18] = mk(0, 0, 0,  0,  0,  0, 0, 1, 0, 0, O_FL,   0, 0);

        for (int i = 0; i < 19; i++) run_vec("tbl", i, tbl[i]);

        // Timeout: entry cycle in RUN, then 20 MEM_WAIT cycles; err visible from the 16th.
        run_vec("tmo", 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_MS, 0, 0));
        for (int m = 1; m <= 20; m++)
            run_vec("tmo", m, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_MS, (m > MT) ? 1'b1 : 1'b0, 2));
        run_vec("tmo", 21, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, O_NORM, 1, 2));
        run_vec("tmo", 22, mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, O_FL,   1, 0));
        run_vec("tmo", 23, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RST,  1, 0));
        run_vec("tmo", 24, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NORM, 0, 0));

        // Reset in the second MEM_WAIT cycle.
        run_vec("rmw", 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_MS,   0, 0));
        run_vec("rmw", 1, mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, O_MS,   0, 2));
        run_vec("rmw", 2, mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, O_RST,  0, 2));
        run_vec("rmw", 3, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NORM, 0, 0));

        // Reset during LU_HOLD, then the same hazard re-detected from RUN.
        run_vec("rlu", 0, mk(0, 1, 7, 0, 7, 0, 1, 0, 0, 0, O_LU,   0, 0));
        run_vec("rlu", 1, mk(1, 1, 7, 0, 7, 0, 1, 0, 0, 0, O_RST,  0, 1));
        run_vec("rlu", 2, mk(0, 1, 7, 0, 7, 0, 1, 0, 0, 0, O_LU,   0, 0));
        run_vec("rlu", 3, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NORM, 0, 1));
        run_vec("rlu", 4, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NORM, 0, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
